bytebeat_sequencer: RTL and testbench
=====================================

# bytebeat_sequencer

Sample-rate controller that sits between the top-level pin wrapper and the `bytebeat` core. It divides `clk` down to a programmable sample tick and captures the four 4-bit expression parameters on each tick. It drives them into the core's `a/b/c/d` valid/ready channels, collects one PCM byte per tick from the core's output channel, and holds that byte steady on the output pins. Late samples are counted as underruns instead of stalling the tick.

## Interface
Parameters:
- `DIV_W`, 16, width of the sample-period divider.
- `RESET_DIV`, 1249, divider value used while `div_load` has never been pulsed (8 kHz at 10 MHz).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run the sample tick; low = idle after the current transaction.
- `div`  in  DIV_W  sample period minus one.
- `div_load`  in  1  pulse: capture `div` into the pending-divider register.
- `params`  in  16  `{d,c,b,a}` nibbles, sampled on tick.
- `a_r`, `b_r`, `c_r`, `d_r`  out  4 each  parameter data to core.
- `a_vld`, `b_vld`, `c_vld`, `d_vld`  out  1 each  parameter valid.
- `a_rdy`, `b_rdy`, `c_rdy`, `d_rdy`  in  1 each  core ready.
- `out_s`  in  8  PCM byte from core.
- `out_vld`  in  1  PCM valid from core.
- `out_rdy`  out  1  sequencer ready for PCM.
- `pcm`  out  8  held PCM sample to pins.
- `pcm_stb`  out  1  one-cycle pulse when `pcm` updates.
- `underrun`  out  8  saturating count of dropped ticks.
- `busy`  out  1  high in LOAD or WAIT_OUT.

## Operation
- Divider: counter `cnt` runs 0..`period`. `tick` fires when `cnt == period` and `enable` is high, then `cnt` returns to 0.
- `div_load` writes the pending divider. The pending value is copied to `period` only when `cnt` wraps or while `enable` is low. `div=0` gives a tick every cycle.
- `cnt` holds at 0 while `enable` is low.
- FSM states: IDLE, LOAD, WAIT_OUT, HOLD.
  - IDLE/HOLD + `tick`: latch `params` into the shadow `a_r..d_r`, set all four pending bits, go to LOAD.
  - LOAD: `x_vld` = pending bit x. A channel clears its bit on `x_vld & x_rdy`, with each channel handled independently. When the last bit clears (several may clear in the same cycle), go to WAIT_OUT on the next cycle.
  - WAIT_OUT: `out_rdy=1`. On `out_vld`: `pcm <= out_s`, `pcm_stb=1` on the following cycle, go to HOLD.
  - HOLD + `!enable`: go to IDLE.
- Shadow parameter registers are stable for the whole of LOAD, whatever `params` does.
- `tick` while in LOAD or WAIT_OUT:
  - the tick is dropped;
  - `underrun` increments and saturates at 255;
  - `pcm` is unchanged;
  - the in-flight transaction continues.
- `enable` falling in LOAD or WAIT_OUT: the transaction completes normally (no handshake is abandoned), then the FSM enters HOLD and then IDLE.
- `underrun` clears only on reset.

## Timing
- Reset (async assert, synchronous-to-clk deassert is the caller's job): state IDLE, `cnt=0`, `period=RESET_DIV`, `a_r..d_r=0`, all `x_vld=0`, `out_rdy=0`, `pcm=0`, `pcm_stb=0`, `underrun=0`, `busy=0`.
- Reset mid-transaction drops all valids and `out_rdy` immediately. There is no partial-transaction resume.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Tick at cycle T (core always ready, `out_vld` tied high):
  - `x_vld` high at T+1, accepted at T+1;
  - `out_rdy` high at T+2;
  - `pcm`/`pcm_stb` update at T+3.
- Minimum loss-free period is therefore `div >= 2` with a zero-wait core.
- `x_vld` stays high until accepted and never drops before acceptance. `x_r` does not change while `x_vld` is high.
- `pcm_stb` is exactly one cycle per accepted PCM byte.

## Test plan
- Reset, `enable=1`, `div=9` loaded, core ready/valid tied high:
  - `pcm_stb` every 10 cycles;
  - `pcm` tracks `out_s`;
  - first `x_vld` at tick+1, `pcm` at tick+3;
  - `underrun` stays 0.
- Staggered readiness: `b_rdy` held low for 5 cycles after the others accept.
  - `a/c/d_vld` drop after one cycle; `b_vld` holds with stable `b_r` until accepted.
  - WAIT_OUT is entered one cycle after `b` is accepted.
- Underrun: `div=3`, `out_vld` withheld for 12 cycles.
  - `underrun` increments on each dropped tick (expect 3);
  - `pcm` holds its old value;
  - count saturates at 255 in a long stall.
- Divider change: `div_load` with `div=4` while `period=9` mid-count. The current period completes at 10 cycles, and subsequent ticks are 5 cycles apart.
- `enable` deasserted during WAIT_OUT: the PCM byte is still accepted with one `pcm_stb`, the FSM goes to IDLE, no further ticks occur, and `cnt` stays 0.
- `rst_n` asserted during LOAD: valids and `out_rdy` go low the same cycle, all outputs take reset values, and normal operation resumes after release.

Source files
------------

// File: rtl/bytebeat_if.sv
// Parameter and PCM valid/ready channels between the sequencer
// and the bytebeat core.
interface bytebeat_if;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] c_r;
    logic [3:0] d_r;
    logic       a_vld;
    logic       b_vld;
    logic       c_vld;
    logic       d_vld;
    logic       a_rdy;
    logic       b_rdy;
    logic       c_rdy;
    logic       d_rdy;
    logic [7:0] out_s;
    logic       out_vld;
    logic       out_rdy;

    modport master (
        output a_r, b_r, c_r, d_r,
        output a_vld, b_vld, c_vld, d_vld,
        input  a_rdy, b_rdy, c_rdy, d_rdy,
        input  out_s, out_vld,
        output out_rdy
    );

    modport slave (
        input  a_r, b_r, c_r, d_r,
        input  a_vld, b_vld, c_vld, d_vld,
        output a_rdy, b_rdy, c_rdy, d_rdy,
        output out_s, out_vld,
        input  out_rdy
    );
endinterface

// File: rtl/bytebeat_sequencer.sv
// Sample-rate tick generator feeding the bytebeat core and
// holding one PCM byte per tick on the output pins.
module bytebeat_sequencer #(
    parameter int          DIV_W     = 16,
    parameter int unsigned RESET_DIV = 1249
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    input  logic [15:0]      params,
    bytebeat_if.master       core,
    output logic [7:0]       pcm,
    output logic             pcm_stb,
    output logic [7:0]       underrun,
    output logic             busy
);
    localparam logic [DIV_W-1:0] RST_P = RESET_DIV[DIV_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_div_pend;
    logic [15:0]      r_shadow;
    logic [3:0]       r_pend;
    logic             r_out_rdy;
    logic             r_busy;
    logic             r_pcm_stb;
    logic [7:0]       r_pcm;
    logic [7:0]       r_underrun;

    logic             w_wrap;
    logic             w_tick;
    logic [3:0]       w_rdy;
    logic [3:0]       w_pend_nxt;
    logic             w_accept;
    logic             w_start;
    logic             w_drop;

    assign w_wrap     = (r_cnt == r_period);
    assign w_tick     = enable & w_wrap;
    assign w_rdy      = {core.d_rdy, core.c_rdy,
                         core.b_rdy, core.a_rdy};
    assign w_pend_nxt = r_pend & ~w_rdy;
    assign w_accept   = core.out_vld & r_out_rdy;

    // New divider only takes effect on a period boundary or while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_period   <= RST_P;
            r_div_pend <= RST_P;
        end else begin
            if (div_load)
                r_div_pend <= div;
            if (!enable || w_wrap)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + DIV_W'(1);
            if (!enable || w_wrap)
                r_period <= r_div_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_drop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_tick;
                if (w_tick)
                    w_next = S_LOAD;
            end
            S_LOAD: begin
                w_drop = w_tick;
                if (w_pend_nxt == 4'b0000)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                w_drop = w_tick;
                if (w_accept)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                w_start = w_tick;
                if (w_tick)
                    w_next = S_LOAD;
                else if (!enable)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_pend     <= '0;
            r_out_rdy  <= 1'b0;
            r_busy     <= 1'b0;
            r_pcm_stb  <= 1'b0;
            r_pcm      <= '0;
            r_underrun <= '0;
        end else begin
            if (w_start) begin
                r_shadow <= params;
                r_pend   <= 4'b1111;
            end else if (r_state == S_LOAD) begin
                r_pend <= w_pend_nxt;
            end
            r_out_rdy <= (w_next == S_WAIT);
            r_busy    <= (w_next == S_LOAD) ||
                         (w_next == S_WAIT);
            r_pcm_stb <= w_accept;
            if (w_accept)
                r_pcm <= core.out_s;
            if (w_drop && r_underrun != 8'hFF)
                r_underrun <= r_underrun + 8'd1;
        end
    end

    assign core.a_r     = r_shadow[3:0];
    assign core.b_r     = r_shadow[7:4];
    assign core.c_r     = r_shadow[11:8];
    assign core.d_r     = r_shadow[15:12];
    assign core.a_vld   = r_pend[0];
    assign core.b_vld   = r_pend[1];
    assign core.c_vld   = r_pend[2];
    assign core.d_vld   = r_pend[3];
    assign core.out_rdy = r_out_rdy;

    assign pcm      = r_pcm;
    assign pcm_stb  = r_pcm_stb;
    assign underrun = r_underrun;
    assign busy     = r_busy;
endmodule

// File: tb/tb_bytebeat_sequencer.sv
// Directed bench for bytebeat_sequencer with a PCM scoreboard
// and a per-cycle channel protocol monitor.
module tb_bytebeat_sequencer;
    localparam int DIV_W = 16;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             enable   = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div      = '0;
    logic [15:0]      params   = '0;
    logic [7:0]       pcm;
    logic [7:0]       underrun;
    logic             pcm_stb;
    logic             busy;

    logic [3:0] rdy  = 4'hF;
    logic       ovld = 1'b1;
    logic [7:0] osv  = 8'h11;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         vld_q[$];
    int         ordy_q[$];
    int         stb_q[$];

    bytebeat_if bif ();

    assign bif.a_rdy   = rdy[0];
    assign bif.b_rdy   = rdy[1];
    assign bif.c_rdy   = rdy[2];
    assign bif.d_rdy   = rdy[3];
    assign bif.out_s   = osv;
    assign bif.out_vld = ovld;

    wire [3:0]  w_v = {bif.d_vld, bif.c_vld, bif.b_vld, bif.a_vld};
    wire [15:0] w_d = {bif.d_r, bif.c_r, bif.b_r, bif.a_r};

    bytebeat_sequencer #(
        .DIV_W     (DIV_W),
        .RESET_DIV (1249)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .div      (div),
        .div_load (div_load),
        .params   (params),
        .core     (bif),
        .pcm      (pcm),
        .pcm_stb  (pcm_stb),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            osv = osv + 8'd29;
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bif.a_vld;
            1:       return bif.out_rdy;
            default: return pcm_stb;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel,
                            output int at);
        int k;
        k = 0;
        while (sig(sel) !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk(tag, sig(sel), 1);
        at = cyc;
    endtask

    // Protocol monitor and scoreboard, sampled mid-cycle
    logic [3:0]  pv;
    logic [3:0]  pr;
    logic [15:0] pd;
    logic [7:0]  ppcm;
    logic        pordy;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv    = '0;
            pr    = '0;
            pd    = '0;
            ppcm  = '0;
            pordy = 1'b0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i]) begin
                    chk($sformatf("vld_hold%0d", i), w_v[i], 1);
                    chk($sformatf("data_hold%0d", i),
                        w_d[i*4 +: 4], pd[i*4 +: 4]);
                end
            end
            if (w_v[0] && !pv[0]) vld_q.push_back(cyc);
            if (bif.out_rdy && !pordy) ordy_q.push_back(cyc);
            if (pcm_stb) begin
                stb_q.push_back(cyc);
                if (exp_q.size() == 0)
                    chk("stb_without_byte", pcm_stb, 0);
                else
                    chk("pcm", pcm, exp_q.pop_front());
            end else begin
                chk("pcm_hold", pcm, ppcm);
            end
            if (bif.out_vld && bif.out_rdy) exp_q.push_back(bif.out_s);
            pv    = w_v;
            pr    = rdy;
            pd    = w_d;
            ppcm  = pcm;
            pordy = bif.out_rdy;
        end
    end

    task automatic load_div(input logic [DIV_W-1:0] v);
        div      = v;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic clear_logs();
        vld_q.delete();
        ordy_q.delete();
        stb_q.delete();
    endtask

    initial begin
        int e, v, w, c, v1;
        logic [7:0] pcm0;

        #1 rst_n = 1'b0;
        step(2);
        chk("rst_pcm", pcm, 0);
        chk("rst_stb", pcm_stb, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_rdy", bif.out_rdy, 0);
        chk("rst_vld", w_v, 0);
        chk("rst_data", w_d, 0);
        chk("rst_period", dut.r_period, 1249);

        // steady run, div = 9
        rst_n  = 1'b1;
        params = 16'h4321;
        load_div(16'd9);
        step(2);
        clear_logs();
        enable = 1'b1;
        e = cyc;
        step(45);
        chk("n_ticks", vld_q.size(), 4);
        chk("n_stb", stb_q.size(), 4);
        if (vld_q.size() >= 2) begin
            chk("first_vld", vld_q[0], e + 10);
            chk("vld_period", vld_q[1] - vld_q[0], 10);
        end
        if (ordy_q.size() >= 1)
            chk("first_out_rdy", ordy_q[0], e + 11);
        if (stb_q.size() >= 2) begin
            chk("first_stb", stb_q[0], e + 12);
            chk("stb_period", stb_q[1] - stb_q[0], 10);
        end
        chk("underrun_steady", underrun, 0);

        // b held off for 5 cycles
        rdy = 4'b1101;
        wait_for("wait_vld_stag", 0, v);
        chk("stag_vld_all", w_v, 4'hF);
        chk("stag_shadow", w_d, 16'h4321);
        params = 16'hFFFF;
        step();
        chk("stag_vld_b_only", w_v, 4'b0010);
        chk("stag_b_r", bif.b_r, 4'h2);
        step(3);
        chk("stag_b_hold", bif.b_vld, 1);
        chk("stag_no_ordy", bif.out_rdy, 0);
        step();
        rdy = 4'hF;
        chk("stag_ordy_pre", bif.out_rdy, 0);
        step();
        chk("stag_vld_clear", w_v, 0);
        chk("stag_ordy_post", bif.out_rdy, 1);
        chk("stag_busy", busy, 1);
        params = 16'h4321;
        step(4);
        chk("stag_underrun", underrun, 0);

        // underrun with div = 3
        load_div(16'd3);
        step(25);
        wait_for("wait_stb_ur", 2, c);
        ovld = 1'b0;
        pcm0 = pcm;
        wait_for("wait_ordy_ur", 1, w);
        step(10);
        chk("underrun_2", underrun, 2);
        step();
        chk("underrun_3", underrun, 3);
        chk("underrun_pcm_hold", pcm, pcm0);
        step();
        ovld = 1'b1;
        step(4);
        chk("underrun_after", underrun, 3);

        wait_for("wait_stb_sat", 2, c);
        ovld = 1'b0;
        pcm0 = pcm;
        step(1100);
        chk("underrun_sat", underrun, 255);
        chk("sat_pcm_hold", pcm, pcm0);
        ovld = 1'b1;
        step(10);
        chk("underrun_sat_keep", underrun, 255);

        // divider change mid-count
        load_div(16'd9);
        step(20);
        if (bif.a_vld) step();
        wait_for("wait_vld_div", 0, v1);
        step(2);
        load_div(16'd4);
        clear_logs();
        step(22);
        chk("div_n_ticks", vld_q.size(), 3);
        if (vld_q.size() >= 3) begin
            chk("div_old_period", vld_q[0], v1 + 10);
            chk("div_new_period1", vld_q[1], v1 + 15);
            chk("div_new_period2", vld_q[2], v1 + 20);
        end

        // enable dropped during WAIT_OUT
        wait_for("wait_stb_en", 2, c);
        ovld = 1'b0;
        wait_for("wait_ordy_en", 1, w);
        step();
        enable = 1'b0;
        step();
        ovld = 1'b1;
        clear_logs();
        step(30);
        chk("en_one_stb", stb_q.size(), 1);
        if (stb_q.size() >= 1)
            chk("en_stb_time", stb_q[0], w + 3);
        chk("en_no_ticks", vld_q.size(), 0);
        chk("en_busy", busy, 0);
        chk("en_out_rdy", bif.out_rdy, 0);
        chk("en_cnt", dut.r_cnt, 0);

        // reset during LOAD
        rdy    = 4'b1101;
        enable = 1'b1;
        wait_for("wait_vld_rst", 0, v);
        step();
        chk("pre_rst_b_vld", bif.b_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", w_v, 0);
        chk("mid_rst_ordy", bif.out_rdy, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pcm", pcm, 0);
        chk("mid_rst_stb", pcm_stb, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_data", w_d, 0);
        step(2);
        enable = 1'b0;
        rdy    = 4'hF;
        rst_n  = 1'b1;
        step();
        load_div(16'd9);
        step(2);
        clear_logs();
        enable = 1'b1;
        e = cyc;
        step(25);
        chk("resume_n_stb", stb_q.size(), 2);
        if (vld_q.size() >= 1)
            chk("resume_first_vld", vld_q[0], e + 10);
        else
            chk("resume_first_vld", vld_q.size(), 1);
        chk("resume_underrun", underrun, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
